// File: rtl/pcs_pkg.sv
// Shared PCS definitions: sync-header codes, gearbox sequence constants and
// the gearbox state type. Imported by the encoder and the TX gearbox.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int GEARBOX_SEQ_CYCLES  = 66;
  localparam int GEARBOX_PAUSE_START = 64;

  localparam int GB_DATA_W = 32;
  localparam int GB_HDR_W  = 2;
  localparam int GB_BUF_W  = 96;
  localparam int GB_FILL_W = 7;
  localparam int GB_SEQ_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } gearbox_state_t;

  // Bits appended for one word: the first word of a block carries the header too.
  function automatic logic [GB_FILL_W-1:0] block_append_len(input logic word_parity);
    return word_parity ? GB_FILL_W'(GB_DATA_W) : GB_FILL_W'(GB_DATA_W + GB_HDR_W);
  endfunction

endpackage

// File: rtl/bit_accumulator.sv
// Bit accumulator for the TX gearbox: appends a variable-length chunk above
// the current fill and optionally extracts the lowest OUT_W bits in the same cycle.
module bit_accumulator
  import pcs_pkg::*;
#(
  parameter int BUF_W  = GB_BUF_W,
  parameter int IN_W   = GB_DATA_W + GB_HDR_W,
  parameter int OUT_W  = GB_DATA_W,
  parameter int FILL_W = GB_FILL_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic [IN_W-1:0]   i_append_data,
  input  logic [FILL_W-1:0] i_append_len,
  input  logic              i_extract,
  output logic [OUT_W-1:0]  o_extract_data
);

  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic [BUF_W-1:0]  w_mask;
  logic [BUF_W-1:0]  w_merged;
  logic [FILL_W-1:0] w_fill_app;

  // Masking makes the chunk length authoritative regardless of stale upper bits.
  always_comb begin
    w_mask     = (BUF_W'(1) << i_append_len) - BUF_W'(1);
    w_merged   = r_buf | ((BUF_W'(i_append_data) & w_mask) << r_fill);
    w_fill_app = r_fill + i_append_len;
  end

  assign o_extract_data = w_merged[OUT_W-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (i_flush) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (i_extract) begin
      r_buf  <= {{OUT_W{1'b0}}, w_merged[BUF_W-1:OUT_W]};
      r_fill <= w_fill_app - FILL_W'(OUT_W);
    end else begin
      r_buf  <= w_merged;
      r_fill <= w_fill_app;
    end
  end

endmodule

// File: rtl/tx_gearbox.sv
// TX 66b-to-32b gearbox: packs header+payload blocks into a continuous 32-bit
// SERDES stream, pausing upstream 2 of every 66 cycles. Optional macro TX_GEARBOX_ERR_CNT_EN.
module tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  input  logic                  i_data_valid,
  output logic                  o_gearbox_pause,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_gearbox_err
`ifdef TX_GEARBOX_ERR_CNT_EN
  ,
  input  logic                  i_err_count_clr,
  output logic [15:0]           o_err_count
`endif
);

  localparam int SEQ_CYCLES = GEARBOX_SEQ_CYCLES;
  localparam int BLK_W      = DATA_WIDTH + HDR_WIDTH;

  gearbox_state_t        r_state, w_state_nxt;
  logic [GB_SEQ_W-1:0]   r_seq_cnt, w_seq_cnt_nxt;
  logic                  r_parity, w_parity_nxt;
  logic                  w_accept;
  logic                  w_underrun;
  logic                  w_overrun;
  logic                  w_extract;
  logic [BLK_W-1:0]      w_append_data;
  logic [GB_FILL_W-1:0]  w_append_len;
  logic [DATA_WIDTH-1:0] w_extract_data;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic                  r_err;

  // Upstream handshake: a word transfers on any cycle with i_data_valid=1 while
  // o_gearbox_pause=0. Pause is an inverted ready that depends on state only, so
  // valid during pause is an overrun and missing valid during RUN is an underrun.
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_cnt_nxt = r_seq_cnt;
    w_parity_nxt  = r_parity;
    w_accept      = 1'b0;
    w_underrun    = 1'b0;
    w_overrun     = 1'b0;
    w_extract     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_data_valid) begin
          w_accept      = 1'b1;
          w_extract     = 1'b1;
          w_state_nxt   = RUN;
          w_seq_cnt_nxt = GB_SEQ_W'(1);
          w_parity_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (i_data_valid) begin
          w_accept      = 1'b1;
          w_extract     = 1'b1;
          w_parity_nxt  = ~r_parity;
          w_seq_cnt_nxt = r_seq_cnt + 1'b1;
          if (r_seq_cnt == GB_SEQ_W'(GEARBOX_PAUSE_START - 1)) begin
            w_state_nxt = PAUSE;
          end
        end else begin
          w_underrun    = 1'b1;
          w_state_nxt   = IDLE;
          w_seq_cnt_nxt = '0;
          w_parity_nxt  = 1'b0;
        end
      end
      PAUSE: begin
        w_extract = 1'b1;
        w_overrun = i_data_valid;
        if (r_seq_cnt == GB_SEQ_W'(SEQ_CYCLES - 1)) begin
          w_state_nxt   = RUN;
          w_seq_cnt_nxt = '0;
        end else begin
          w_seq_cnt_nxt = r_seq_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_seq_cnt_nxt = '0;
        w_parity_nxt  = 1'b0;
      end
    endcase
  end

  // Header sits below the payload so it is serialized first.
  always_comb begin
    w_append_data = r_parity ? {{HDR_WIDTH{1'b0}}, i_data} : {i_data, i_sync_hdr};
    w_append_len  = w_accept ? block_append_len(r_parity) : '0;
  end

  bit_accumulator #(
    .BUF_W  (GB_BUF_W),
    .IN_W   (BLK_W),
    .OUT_W  (DATA_WIDTH),
    .FILL_W (GB_FILL_W)
  ) u_acc (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_flush        (w_underrun),
    .i_append_data  (w_append_data),
    .i_append_len   (w_append_len),
    .i_extract      (w_extract),
    .o_extract_data (w_extract_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_seq_cnt <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seq_cnt <= w_seq_cnt_nxt;
      r_parity  <= w_parity_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_data  <= w_extract ? w_extract_data : '0;
      r_tx_valid <= w_extract;
      r_err      <= w_underrun | w_overrun;
    end
  end

  assign o_gearbox_pause = (r_state == PAUSE);
  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_gearbox_err   = r_err;

`ifdef TX_GEARBOX_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err_count <= '0;
    end else if (i_err_count_clr) begin
      r_err_count <= '0;
    end else if ((w_underrun || w_overrun) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_tx_gearbox.sv
// Self-checking bench for tx_gearbox: a bit-level model of the block stream
// feeds an expected-word queue that is drained as the DUT emits words.
module tb_tx_gearbox;
  import pcs_pkg::*;

  logic        i_clk        = 1'b0;
  logic        i_reset_n    = 1'b0;
  logic [31:0] i_data       = '0;
  logic [1:0]  i_sync_hdr   = '0;
  logic        i_data_valid = 1'b0;
  logic        o_gearbox_pause;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_gearbox_err;
`ifdef TX_GEARBOX_ERR_CNT_EN
  logic        i_err_count_clr = 1'b0;
  logic [15:0] o_err_count;
`endif

  tx_gearbox dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_data          (i_data),
    .i_sync_hdr      (i_sync_hdr),
    .i_data_valid    (i_data_valid),
    .o_gearbox_pause (o_gearbox_pause),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .o_gearbox_err   (o_gearbox_err)
`ifdef TX_GEARBOX_ERR_CNT_EN
    ,
    .i_err_count_clr (i_err_count_clr),
    .o_err_count     (o_err_count)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [31:0]    exp_q[$];
  bit             bit_q[$];
  gearbox_state_t m_state  = IDLE;
  int             m_seq    = 0;
  bit             m_par    = 1'b0;
  int             m_ecnt   = 0;
  logic [31:0]    pat_cnt  = 32'h0000_0100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_seq   = 0;
    m_par   = 1'b0;
    m_ecnt  = 0;
    bit_q.delete();
    exp_q.delete();
  endtask

  // Serial order: header bit 0, header bit 1, then payload bit 0 upward.
  task automatic model_push(input logic [31:0] d, input logic [1:0] h, input bit par);
    if (!par) begin
      bit_q.push_back(h[0]);
      bit_q.push_back(h[1]);
    end
    for (int i = 0; i < 32; i++) bit_q.push_back(d[i]);
  endtask

  task automatic model_emit();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (bit_q.size() > 0) w[i] = bit_q.pop_front();
    end
    exp_q.push_back(w);
  endtask

  // driver: one clock of stimulus, model update, then output checks
  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] h, input bit clr);
    bit e_err, e_valid, wrapped;
    i_data_valid = v;
    i_data       = d;
    i_sync_hdr   = h;
`ifdef TX_GEARBOX_ERR_CNT_EN
    i_err_count_clr = clr;
`endif
    e_err   = 1'b0;
    e_valid = 1'b0;
    wrapped = 1'b0;
    case (m_state)
      IDLE: begin
        if (v) begin
          model_push(d, h, 1'b0);
          model_emit();
          e_valid = 1'b1;
          m_state = RUN;
          m_seq   = 1;
          m_par   = 1'b1;
        end
      end
      RUN: begin
        if (v) begin
          model_push(d, h, m_par);
          model_emit();
          e_valid = 1'b1;
          m_par   = !m_par;
          m_seq++;
          if (m_seq == GEARBOX_PAUSE_START) m_state = PAUSE;
        end else begin
          e_err   = 1'b1;
          bit_q.delete();
          m_state = IDLE;
          m_seq   = 0;
          m_par   = 1'b0;
        end
      end
      default: begin
        model_emit();
        e_valid = 1'b1;
        e_err   = v;
        if (m_seq == GEARBOX_SEQ_CYCLES - 1) begin
          m_seq   = 0;
          m_state = RUN;
          wrapped = 1'b1;
        end else begin
          m_seq++;
        end
      end
    endcase
    if (clr) m_ecnt = 0;
    else if (e_err && m_ecnt < 65535) m_ecnt++;

    @(posedge i_clk);
    @(negedge i_clk);
    check_eq("pause", o_gearbox_pause, (m_state == PAUSE));
    check_eq("err", o_gearbox_err, e_err);
    check_eq("tx_valid", o_tx_valid, e_valid);
    // scoreboard
    if (o_tx_valid) begin
      if (exp_q.size() == 0) check_eq("exp_q_avail", exp_q.size(), 1);
      else check_eq("tx_data", o_tx_data, exp_q.pop_front());
    end
    if (wrapped) check_eq("fill_at_wrap", dut.u_acc.r_fill, 0);
`ifdef TX_GEARBOX_ERR_CNT_EN
    check_eq("err_count", o_err_count, m_ecnt);
`endif
  endtask

  task automatic next_word(input int mode, output logic [31:0] d, output logic [1:0] h);
    bit par;
    par = (m_state == RUN) ? m_par : 1'b0;
    if (!par) h = (mode == 0) ? SYNC_DATA : (($urandom_range(0, 1) == 1) ? SYNC_DATA : SYNC_CTRL);
    else h = 2'($urandom_range(0, 3));
    if (mode == 0) begin
      d = par ? 32'h5555_5555 : 32'hAAAA_AAAA;
    end else begin
      d = pat_cnt;
      pat_cnt++;
    end
  endtask

  task automatic run_cycles(input int n, input int mode, input bit ovr, input int drop_seq);
    int          drop;
    logic [31:0] d;
    logic [1:0]  h;
    drop = drop_seq;
    for (int i = 0; i < n; i++) begin
      if (m_state == PAUSE) begin
        step(ovr, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      end else if (m_state == RUN && m_seq == drop) begin
        step(1'b0, '0, '0, 1'b0);
        drop = -1;
      end else begin
        next_word(mode, d, h);
        step(1'b1, d, h, 1'b0);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  h;

    // reset state
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_tx_valid", o_tx_valid, 0);
    check_eq("rst_tx_data", o_tx_data, 0);
    check_eq("rst_pause", o_gearbox_pause, 0);
    check_eq("rst_err", o_gearbox_err, 0);
    i_reset_n = 1'b1;
    step(1'b0, '0, '0, 1'b0);

    // constant blocks: first word is {AAAAAAAA[29:0], 2'b01}
    run_cycles(1, 0, 1'b0, -1);
    check_eq("first_word", o_tx_data, 32'hAAAA_AAA9);
    run_cycles(131, 0, 1'b0, -1);

    // three sequences of incrementing payload
    run_cycles(3 * GEARBOX_SEQ_CYCLES, 1, 1'b0, -1);

    // underrun at seq_cnt 20, then restart from IDLE
    run_cycles(100, 1, 1'b0, 20);

    // overrun during both pause cycles of two sequences
    run_cycles(2 * GEARBOX_SEQ_CYCLES, 1, 1'b1, -1);

    // asynchronous reset at seq_cnt 40
    for (int i = 0; i < 200 && !(m_state == RUN && m_seq == 40); i++) begin
      next_word(1, d, h);
      step(1'b1, d, h, 1'b0);
    end
    check_eq("reach_seq40", m_seq, 40);
    #2;
    i_reset_n    = 1'b0;
    i_data_valid = 1'b0;
    #1;
    check_eq("async_tx_valid", o_tx_valid, 0);
    check_eq("async_tx_data", o_tx_data, 0);
    check_eq("async_pause", o_gearbox_pause, 0);
    check_eq("async_err", o_gearbox_err, 0);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    run_cycles(70, 1, 1'b0, -1);

`ifdef TX_GEARBOX_ERR_CNT_EN
    for (int k = 0; k < 3; k++) begin
      next_word(1, d, h);
      step(1'b1, d, h, 1'b0);
      step(1'b0, '0, '0, 1'b0);
    end
    check_eq("err_count_3", o_err_count, 3);
    next_word(1, d, h);
    step(1'b1, d, h, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    check_eq("err_count_clr", o_err_count, 0);
    step(1'b0, '0, '0, 1'b0);
`endif

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_gearbox.md
Name: tx_gearbox

Overview:
- TX 66b-to-32b gearbox directly downstream of the 64b/66b encoder/scrambler path.
- Accepts a 32-bit payload word per cycle, plus a 2-bit sync header on the first word of each 66-bit block.
- Produces a continuous 32-bit stream for the SERDES.
- Absorbs the 2-bit-per-block rate mismatch by asserting o_gearbox_pause for two consecutive cycles, one whole block, every 66 cycles.

Parameters:
- DATA_WIDTH, 32, payload word width; only 32 is supported.
- HDR_WIDTH, 2, sync header width.
- SEQ_CYCLES, 66, length of the gearbox sequence in cycles (64 data cycles + 2 pause cycles); derived, not user-overridable.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  32  scrambled block payload word; lower half of the block first.
- i_sync_hdr  in  2  sync header; sampled only on the first word of a block.
- i_data_valid  in  1  word present on i_data.
- o_gearbox_pause  out  1  upstream must not present data this cycle.
- o_tx_data  out  32  serialized word; bit 0 is transmitted first.
- o_tx_valid  out  1  o_tx_data is valid.
- o_gearbox_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (asynchronous, i_reset_n=0): all outputs 0; state IDLE; seq_cnt=0; fill=0; word_parity=0; buffer cleared.
- Buffer: 96-bit bit-accumulator with a fill count of 0..96.
- Appending:
  - First word of a block (parity 0): append {i_data, i_sync_hdr}, 34 bits; header occupies the lowest new bit positions.
  - Second word (parity 1): append i_data, 32 bits.
- Emit rule: each RUN/PAUSE cycle, after appending, emit the lowest 32 bits to o_tx_data (registered) and subtract 32 from fill.
- Latency: 1 cycle from accepted input to its first bits on o_tx_data.
- State IDLE:
  - o_gearbox_pause=0, o_tx_valid=0.
  - First i_data_valid goes to RUN with seq_cnt=1.
  - That word is treated as parity 0. Next-cycle output = {i_data[29:0], i_sync_hdr}; residual fill=2.
- State RUN:
  - seq_cnt increments on every cycle.
  - At seq_cnt=64 the block moves to PAUSE.
  - i_data_valid is required every cycle.
  - word_parity toggles on each accepted word.
  - Fill residual after block k (k=0..31) is 2(k+1); peak fill is 96 and must never be exceeded.
- State PAUSE (seq_cnt 64,65):
  - o_gearbox_pause=1, driven from registered state, not from inputs.
  - No input accepted; 32 bits drained per cycle.
  - At seq_cnt=65 fill reaches 0; seq_cnt wraps to 0 and the block returns to RUN, with the next input as parity 0.
- o_tx_valid stays 1 continuously from the first output until an error or reset.
- Error cases (each pulses o_gearbox_err for 1 cycle):
  - Underrun: i_data_valid=0 in a RUN cycle. Flush the buffer, return to IDLE, o_tx_valid=0 next cycle.
  - Overrun: i_data_valid=1 during PAUSE. The word is dropped, the sequence continues unaffected.
  - Underrun and overrun cannot coincide, since they occur in disjoint states.
- i_sync_hdr values 2'b00 and 2'b11 are passed through unmodified; not checked here.
- Reset asserted mid-sequence: immediate return to the reset values, no partial word emitted.

Optional Feature:
- Macro: TX_GEARBOX_ERR_CNT_EN.
- Defined:
  - Adds output o_err_count [15:0], a saturating count of underrun plus overrun events.
  - Adds input i_err_count_clr, a synchronous clear; clear wins over a simultaneous increment.
  - Counter resets to 0.
- Undefined: neither port exists and there is no counter logic; all other behaviour is identical.

Decomposition:
- Shared package pcs_pkg:
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
  - GEARBOX_SEQ_CYCLES=66, GEARBOX_PAUSE_START=64.
  - gearbox_state_t enum {IDLE, RUN, PAUSE}.
  - The encoder also imports the sync-header constants from this package.
- Sub-module bit_accumulator: 96-bit append/extract shifter with fill count, ports append_data/append_len/extract; the FSM stays in tx_gearbox.

Test Plan:
- Reset then constant blocks (hdr=2'b01, data=32'hAAAA_AAAA, 32'h5555_5555) -> first o_tx_data=32'hAAAA_AAA9 one cycle after the first valid; o_tx_valid stays 1.
- Run 3 full sequences with an incrementing data pattern -> o_gearbox_pause high exactly at seq_cnt 64,65 of each 66-cycle period. Reassembled output bitstream equals the concatenated 66-bit blocks with no bit loss; fill=0 at every wrap.
- Drop i_data_valid for 1 cycle at seq_cnt=20 -> o_gearbox_err pulse, o_tx_valid=0 next cycle; restart from IDLE on the next valid.
- Drive i_data_valid=1 during both pause cycles -> two o_gearbox_err pulses, words dropped, output stream unchanged versus the reference model.
- Assert i_reset_n=0 at seq_cnt=40 -> outputs 0 in the same cycle (asynchronous); clean restart afterwards.
- With TX_GEARBOX_ERR_CNT_EN: 3 underruns -> o_err_count=3; pulse i_err_count_clr together with an error -> o_err_count=0.
